pll_drp_reconfig: RTL and testbench

//  DRP master that reprograms a PLL at run time over its DADDR/DEN/DI/DO/DRDY port.
//  On START it holds the PLL in reset and walks an external register table.
//  For each table entry it does a read-modify-write over DRP.
//  It then releases the PLL reset and waits for LOCKED.

---
 rtl/pll_drp_reconfig_if.sv | 25 ++
 rtl/pll_drp_reconfig.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_pll_drp_reconfig.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_drp_reconfig_if.sv
// -----------------------------------------------------------------------------
// pll_drp_reconfig_if
//   DRP bus between the reconfiguration master and one PLL DRP port.
//   Signals:
//     daddr  7   DRP address
//     den    1   DRP enable, one-cycle pulse per transaction
//     dwe    1   DRP write enable, valid with den
//     di     16  DRP write data
//     dout   16  DRP read data (the PLL's DO pin; "do" is an SV keyword)
//     drdy   1   transaction complete, dout valid on reads
//   Modports:
//     master  drives daddr/den/dwe/di, samples dout/drdy
//     slave   the PLL (or a model of it)
// -----------------------------------------------------------------------------
interface pll_drp_reconfig_if;
   logic [6:0]  daddr;
   logic        den;
   logic        dwe;
   logic [15:0] di;
   logic [15:0] dout;
   logic        drdy;

   modport master (output daddr, den, dwe, di, input  dout, drdy);
   modport slave  (input  daddr, den, dwe, di, output dout, drdy);
endinterface

// File: rtl/pll_drp_reconfig.sv
// -----------------------------------------------------------------------------
// pll_drp_reconfig
//   Run-time PLL reprogramming over DRP. On an accepted start the PLL is held
//   in reset, every entry of an external register table is read-modify-written
//   (new = (DO & mask) | (data & ~mask)), the PLL reset is released and the
//   block waits for a fresh LOCKED (one that was seen low after the reset rose).
//
//   Optional feature: define DRP_READBACK_EN to read each written register back
//   and compare it against the written word (mismatch -> err_code 3).
//
//   Ports:
//     dclk      in   clock, shared with the PLL DRP clock, rising edge
//     rst       in   synchronous active-high reset
//     start     in   one-cycle request, ignored while busy
//     busy      out  reconfiguration in progress
//     done      out  one-cycle pulse on success
//     err       out  sticky error, cleared by accepted start or rst
//     err_code  out  0 none, 1 DRDY timeout, 2 lock timeout, 3 readback mismatch
//     tbl_idx   out  current table index
//     tbl_addr  in   DRP address of entry tbl_idx (same-cycle lookup)
//     tbl_mask  in   1 = keep readback bit, 0 = take tbl_data bit
//     tbl_data  in   new bit values
//     drp       --   DRP master port (see pll_drp_reconfig_if)
//     pll_rst   out  drives the PLL RST pin
//     locked    in   PLL LOCKED
// -----------------------------------------------------------------------------
module pll_drp_reconfig #(
   parameter int NUM_ENTRIES  = 23,
   parameter int IDX_W        = 7,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic               dclk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [IDX_W-1:0]   tbl_idx,
   input  logic [6:0]         tbl_addr,
   input  logic [15:0]        tbl_mask,
   input  logic [15:0]        tbl_data,
   pll_drp_reconfig_if.master drp,
   output logic               pll_rst,
   input  logic               locked
);

   // One wait counter serves both the DRDY and the lock timeout; it is sized
   // for the larger limit so it can never wrap before a timeout fires.
   localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DRDY_LIM = CNT_W'(DRDY_TIMEOUT);
   localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ASRT,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_WR_WAIT,
`ifdef DRP_READBACK_EN
      S_VFY_REQ,
      S_VFY_WAIT,
`endif
      S_RELEASE,
      S_WAIT_LOCK,
      S_ERROR
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_DRDY = 2'd1,
      ERR_LOCK = 2'd2,
      ERR_VFY  = 2'd3
   } err_e;

   state_e           state_q,    state_d;
   logic [IDX_W-1:0] idx_q,      idx_d;
   logic [6:0]       daddr_q,    daddr_d;
   logic [15:0]      di_q,       di_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             pll_rst_q,  pll_rst_d;
   logic             err_q,      err_d;
   err_e             err_code_q, err_code_d;
   logic             done_q,     done_d;
   logic             low_seen_q, low_seen_d;

   logic             entry_done;
   logic             fail;
   err_e             fail_code;
   logic [15:0]      new_word;
   logic             drdy_expired;
   logic             lock_expired;

   assign new_word     = (drp.dout & tbl_mask) | (tbl_data & ~tbl_mask);
   assign drdy_expired = (cnt_q >= DRDY_LIM);
   assign lock_expired = (cnt_q >= LOCK_LIM);

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge dclk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         daddr_q    <= '0;
         di_q       <= '0;
         cnt_q      <= '0;
         pll_rst_q  <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         done_q     <= 1'b0;
         low_seen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         daddr_q    <= daddr_d;
         di_q       <= di_d;
         cnt_q      <= cnt_d;
         pll_rst_q  <= pll_rst_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         done_q     <= done_d;
         low_seen_q <= low_seen_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and datapath
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      idx_d      = idx_q;
      daddr_d    = daddr_q;
      di_d       = di_q;
      cnt_d      = cnt_q;
      pll_rst_d  = pll_rst_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      done_d     = 1'b0;
      // A stale LOCKED that never dropped must not complete the sequence, so
      // remember any low LOCKED seen since the accepted start.
      low_seen_d = low_seen_q | ~locked;
      entry_done = 1'b0;
      fail       = 1'b0;
      fail_code  = ERR_NONE;

      case (state_q)
         // ERROR reports busy=0, so a start there is accepted exactly as in IDLE.
         S_IDLE, S_ERROR: begin
            if (start) begin
               state_d    = S_ASRT;
               pll_rst_d  = 1'b1;
               idx_d      = '0;
               err_d      = 1'b0;
               err_code_d = ERR_NONE;
               low_seen_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ASRT: state_d = S_RD_REQ;

         // The DEN cycle: capture the address so it stays stable until DRDY,
         // and restart the wait counter (DRDY is not sampled here).
         S_RD_REQ: begin
            daddr_d = tbl_addr;
            cnt_d   = CNT_W'(1);
            state_d = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            if (drp.drdy) begin
               di_d    = new_word;
               state_d = S_WR_REQ;
            end else if (drdy_expired) begin
               fail      = 1'b1;
               fail_code = ERR_DRDY;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_WR_REQ: begin
            cnt_d   = CNT_W'(1);
            state_d = S_WR_WAIT;
         end

         S_WR_WAIT: begin
            if (drp.drdy) begin
`ifdef DRP_READBACK_EN
               state_d = S_VFY_REQ;
`else
               entry_done = 1'b1;
`endif
            end else if (drdy_expired) begin
               fail      = 1'b1;
               fail_code = ERR_DRDY;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

`ifdef DRP_READBACK_EN
         S_VFY_REQ: begin
            cnt_d   = CNT_W'(1);
            state_d = S_VFY_WAIT;
         end

         S_VFY_WAIT: begin
            if (drp.drdy) begin
               if (drp.dout != di_q) begin
                  fail      = 1'b1;
                  fail_code = ERR_VFY;
               end else begin
                  entry_done = 1'b1;
               end
            end else if (drdy_expired) begin
               fail      = 1'b1;
               fail_code = ERR_DRDY;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif

         S_RELEASE: begin
            cnt_d   = CNT_W'(1);
            state_d = S_WAIT_LOCK;
         end

         // Completion takes priority over a timeout expiring in the same cycle.
         S_WAIT_LOCK: begin
            if (low_seen_q && locked) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (lock_expired) begin
               fail      = 1'b1;
               fail_code = ERR_LOCK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      // The NEXT step is folded into the cycle that completes an entry, so the
      // following read issues immediately and an entry costs 4 cycles (6 with
      // readback) when DRDY answers on the next cycle.
      if (entry_done) begin
         if (idx_q == LAST_IDX) begin
            pll_rst_d = 1'b0;
            state_d   = S_RELEASE;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD_REQ;
         end
      end

      // The configuration is incomplete after any failure, so the PLL is kept
      // (or put back) in reset.
      if (fail) begin
         state_d    = S_ERROR;
         err_d      = 1'b1;
         err_code_d = fail_code;
         pll_rst_d  = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      drp.den = 1'b0;
      drp.dwe = 1'b0;
      case (state_q)
         S_RD_REQ:  drp.den = 1'b1;
         S_WR_REQ: begin
            drp.den = 1'b1;
            drp.dwe = 1'b1;
         end
         S_WR_WAIT: drp.dwe = 1'b1;
`ifdef DRP_READBACK_EN
         S_VFY_REQ: drp.den = 1'b1;
`endif
         default: ;
      endcase

      // The read DEN cycle presents the live lookup; afterwards the captured
      // copy holds the address through the write and verify transactions.
      drp.daddr = (state_q == S_RD_REQ) ? tbl_addr : daddr_q;
      drp.di    = di_q;

      busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
      done      = done_q;
      err       = err_q;
      err_code  = err_code_q;
      tbl_idx   = idx_q;
      pll_rst   = pll_rst_q;
   end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// -----------------------------------------------------------------------------
// tb_pll_drp_reconfig
//   Directed bench for pll_drp_reconfig with a two-entry table, a DRP register
//   model that answers after a programmable delay, and a simple PLL lock model.
// -----------------------------------------------------------------------------
module tb_pll_drp_reconfig;

   localparam int NUM_ENTRIES  = 2;
   localparam int IDX_W        = 7;
   localparam int DRDY_TIMEOUT = 64;
   localparam int LOCK_TIMEOUT = 100;
`ifdef DRP_READBACK_EN
   localparam int DPE = 3;   // DEN pulses per entry
`else
   localparam int DPE = 2;
`endif

   logic             dclk;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic             err;
   logic [1:0]       err_code;
   logic [IDX_W-1:0] tbl_idx;
   logic [6:0]       tbl_addr;
   logic [15:0]      tbl_mask;
   logic [15:0]      tbl_data;
   logic             pll_rst;
   logic             locked;

   pll_drp_reconfig_if drp ();

   pll_drp_reconfig #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .IDX_W       (IDX_W),
      .DRDY_TIMEOUT(DRDY_TIMEOUT),
      .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .dclk    (dclk),
      .rst     (rst),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .err_code(err_code),
      .tbl_idx (tbl_idx),
      .tbl_addr(tbl_addr),
      .tbl_mask(tbl_mask),
      .tbl_data(tbl_data),
      .drp     (drp.master),
      .pll_rst (pll_rst),
      .locked  (locked)
   );

   assign tbl_addr = (tbl_idx == '0) ? 7'h28 : 7'h4E;

   initial begin
      dclk = 1'b0;
      forever #5 dclk = ~dclk;
   end

   int cyc = 0;
   always @(posedge dclk) cyc++;

   // ---------------- DRP register model ----------------
   logic [15:0] mem     [128];
   bit          written [128];
   int          resp_delay = 1;  // 0 = never answer
   bit          corrupt    = 0;  // flip bit0 when reading a written register
   int          pend_cnt   = 0;
   bit          pend_rd;
   logic [6:0]  pend_addr;
   int          den_cnt    = 0;
   int          den_cyc [$];
   logic [15:0] wr_data [$];
   logic [6:0]  wr_addr [$];

   always @(negedge dclk) begin
      drp.drdy = 1'b0;
      drp.dout = 16'h0000;
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            drp.drdy = 1'b1;
            if (pend_rd)
               drp.dout = mem[pend_addr] ^ ((corrupt && written[pend_addr]) ? 16'h0001 : 16'h0000);
         end
      end
      if (drp.den === 1'b1) begin
         den_cnt++;
         den_cyc.push_back(cyc);
         pend_rd   = !drp.dwe;
         pend_addr = drp.daddr;
         if (drp.dwe === 1'b1) begin
            mem[drp.daddr]     = drp.di;
            written[drp.daddr] = 1'b1;
            wr_data.push_back(drp.di);
            wr_addr.push_back(drp.daddr);
         end
         if (resp_delay > 0) pend_cnt = resp_delay;
      end
   end

   // ---------------- PLL lock model ----------------
   bit lock_auto  = 1;   // 1: low while pll_rst, high 4 cycles after release
   bit lock_force = 1;   // level used when lock_auto = 0
   int lock_ctr   = 0;

   always @(negedge dclk) begin
      if (!lock_auto) begin
         locked = lock_force;
      end else if (pll_rst === 1'b1) begin
         locked   = 1'b0;
         lock_ctr = 0;
      end else if (lock_ctr < 4) begin
         lock_ctr++;
      end else begin
         locked = 1'b1;
      end
   end

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge dclk);
      #1;
   endtask

   task automatic init_mem(input logic [15:0] v);
      for (int a = 0; a < 128; a++) begin
         mem[a]     = v;
         written[a] = 1'b0;
      end
   endtask

   task automatic clear_logs();
      den_cnt = 0;
      den_cyc.delete();
      wr_data.delete();
      wr_addr.delete();
   endtask

   typedef struct {
      int   done_cnt;
      bit   timed_out;
      int   end_cyc;
      int   rel_cyc;
      logic busy0;
      logic err0;
      logic done_end;
   } run_t;

   // Pulse start and run until busy drops (bounded), then watch 3 more cycles.
   task automatic run_cfg(input int budget, output run_t r);
      r.done_cnt  = 0;
      r.timed_out = 1'b1;
      r.end_cyc   = -1;
      r.rel_cyc   = -1;
      r.done_end  = 1'b0;
      start = 1'b1;
      step(1);
      start = 1'b0;
      r.busy0 = busy;
      r.err0  = err;
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (done) r.done_cnt++;
         if (!pll_rst && r.rel_cyc < 0) r.rel_cyc = cyc;
         if (!busy) begin
            r.timed_out = 1'b0;
            r.end_cyc   = cyc;
            r.done_end  = done;
            break;
         end
      end
      repeat (3) begin
         step(1);
         if (done) r.done_cnt++;
      end
   endtask

   function automatic logic [15:0] q16(input int k);
      return (wr_data.size() > k) ? wr_data[k] : 16'hxxxx;
   endfunction

   typedef struct {
      logic [15:0] do_val;
      logic [15:0] mask;
      logic [15:0] data;
      logic [15:0] exp_di;
   } vec_t;

   vec_t vecs [5];
   run_t r;
   bit   found;
   bit   done_seen;
   int   n_den;

   initial begin
      vecs[0] = '{do_val: 16'hFFFF, mask: 16'hFF00, data: 16'h0012, exp_di: 16'hFF12};
      vecs[1] = '{do_val: 16'h0000, mask: 16'hFF00, data: 16'h1234, exp_di: 16'h0034};
      vecs[2] = '{do_val: 16'hA5A5, mask: 16'h0F0F, data: 16'hFFFF, exp_di: 16'hF5F5};
      vecs[3] = '{do_val: 16'h1234, mask: 16'hFFFF, data: 16'h0000, exp_di: 16'h1234};
      vecs[4] = '{do_val: 16'h1234, mask: 16'h0000, data: 16'hBEEF, exp_di: 16'hBEEF};

      tbl_mask = 16'hFF00;
      tbl_data = 16'h0012;
      init_mem(16'hFFFF);

      // ---- 1: reset with start asserted ----
      rst   = 1'b1;
      start = 1'b1;
      step(2);
      check("reset_outputs",
            {busy, done, err, err_code, tbl_idx, drp.daddr, drp.den, drp.dwe, drp.di, pll_rst},
            64'h0);
      check("reset_no_den", den_cnt, 0);
      start = 1'b0;
      rst   = 1'b0;
      step(6);
      check("reset_start_not_latched", {busy, pll_rst}, 2'b00);

      // ---- 2: nominal read-modify-write, table-driven ----
      for (int i = 0; i < 5; i++) begin
         init_mem(vecs[i].do_val);
         tbl_mask = vecs[i].mask;
         tbl_data = vecs[i].data;
         clear_logs();
         run_cfg(300, r);
         check($sformatf("v%0d_ends", i), r.timed_out, 0);
         check($sformatf("v%0d_done_once", i), r.done_cnt, 1);
         check($sformatf("v%0d_err", i), {err, err_code}, 3'b000);
         check($sformatf("v%0d_writes", i), wr_data.size(), NUM_ENTRIES);
         check($sformatf("v%0d_di0", i), q16(0), vecs[i].exp_di);
         check($sformatf("v%0d_di1", i), q16(1), vecs[i].exp_di);
      end
      // Details of the last nominal run
      check("nom_busy_after_start", r.busy0, 1);
      check("nom_done_with_busy_low", r.done_end, 1);
      check("nom_pll_rst_released", pll_rst, 0);
      check("nom_addrs", (wr_addr.size() == 2) ? {wr_addr[0], wr_addr[1]} : 14'h0, {7'h28, 7'h4E});
      check("nom_den_count", den_cnt, NUM_ENTRIES * DPE);
      check("nom_entry_cycles", (den_cyc.size() > DPE) ? den_cyc[DPE] - den_cyc[0] : -1, 2 * DPE);

      // ---- 3: DRDY timeout, then a fresh start clears the error ----
      tbl_mask   = 16'hFF00;
      tbl_data   = 16'h0012;
      init_mem(16'hFFFF);
      resp_delay = 0;
      clear_logs();
      run_cfg(200, r);
      check("drdy_to_ends", r.timed_out, 0);
      check("drdy_to_code", {err, err_code}, 3'b101);
      check("drdy_to_latency", (den_cyc.size() > 0) ? r.end_cyc - den_cyc[0] : -1, DRDY_TIMEOUT + 1);
      check("drdy_to_pll_rst", pll_rst, 1);
      check("drdy_to_no_done", r.done_cnt, 0);
      check("drdy_to_one_den", den_cnt, 1);
      resp_delay = 1;
      clear_logs();
      run_cfg(300, r);
      check("restart_clears_err", r.err0, 0);
      check("restart_done", {r.done_cnt, err}, {32'd1, 1'b0});

      // ---- 4a: LOCKED high throughout -> lock timeout ----
      lock_auto  = 0;
      lock_force = 1;
      clear_logs();
      run_cfg(400, r);
      check("lock_to_ends", r.timed_out, 0);
      check("lock_to_no_done", r.done_cnt, 0);
      check("lock_to_code", {err, err_code}, 3'b110);
      check("lock_to_latency", r.end_cyc - r.rel_cyc, LOCK_TIMEOUT + 1);
      check("lock_to_pll_rst", pll_rst, 1);

      // ---- 4b: stale high LOCKED ignored, then a low/high pulse completes ----
      clear_logs();
      start = 1'b1;
      step(1);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (!pll_rst) begin
            found = 1;
            break;
         end
      end
      check("lock_pulse_release", found, 1);
      step(5);
      check("lock_stale_ignored", {busy, done}, 2'b10);
      lock_force = 0;
      step(3);
      lock_force = 1;
      done_seen = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (done) done_seen = 1;
         if (!busy) break;
      end
      check("lock_pulse_done", {done_seen, busy, err}, 3'b100);
      lock_auto = 1;
      step(6);

      // ---- 5: reset during WR_WAIT of entry 1, late DRDY ignored ----
      resp_delay = 3;
      clear_logs();
      start = 1'b1;
      step(1);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (tbl_idx == 1 && drp.dwe && !drp.den) begin
            found = 1;
            break;
         end
      end
      check("abort_reached_wr_wait", found, 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("abort_outputs", {busy, pll_rst, drp.den, tbl_idx}, '0);
      n_den = den_cnt;
      step(8);
      check("abort_no_more_den", den_cnt, n_den);
      check("abort_stays_idle", {busy, done, err}, 3'b000);
      resp_delay = 1;
      step(4);

      // ---- 6: readback corrupts bit0 ----
      corrupt  = 1;
      tbl_mask = 16'hFF00;
      tbl_data = 16'h0012;
      init_mem(16'hFFFF);
      clear_logs();
      run_cfg(300, r);
      check("rb_ends", r.timed_out, 0);
`ifdef DRP_READBACK_EN
      check("rb_code", {err, err_code}, 3'b111);
      check("rb_no_done", r.done_cnt, 0);
      check("rb_den_stops", den_cnt, 3);
`else
      check("rb_code", {err, err_code}, 3'b000);
      check("rb_done", r.done_cnt, 1);
      check("rb_den_count", den_cnt, 4);
`endif
      corrupt = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
